if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline; sits directly upstream of the IF/ID buffer and cpu_control.
- Owns the fetch PC and drives the instruction-memory (I-cache) read port.
- Buffers fetched words in a 2-entry queue and presents the head as the IF packet.
- Accepts the pipeline-advance signal and branch/jump redirects from control, squashing any wrong-path fetch still in flight.

Parameters:
- RESET_PC, 32'h00000060, fetch address after reset.
- NOP_INST, 32'h00000013, value of if_inst whenever if_valid=0.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- advance  in  1  pipeline moves this cycle (control's load_buffers); pops the queue head if if_valid.
- redirect  in  1  control-flow change resolved in EX.
- redirect_pc  in  32  target PC; bits [1:0] are forced to 0 internally.
- inst_mem_read  out  1  read request to I-cache.
- inst_mem_address  out  32  word-aligned fetch address.
- inst_mem_rdata  in  32  instruction word; valid only when inst_mem_resp=1.
- inst_mem_resp  in  1  read complete; only meaningful while inst_mem_read=1.
- if_valid  out  1  queue non-empty; the head is presented on if_pc/if_inst.
- if_pc  out  32  PC of the head entry.
- if_inst  out  32  instruction of the head entry; NOP_INST when empty.

Behaviour:
- State machine: IDLE (no request), REQ (read outstanding), SQUASH (draining a wrong-path read). inst_mem_read = (state==REQ || state==SQUASH); it is registered, never combinational from inputs.
- Memory rule: once inst_mem_read=1, inst_mem_read and inst_mem_address are held stable until the cycle inst_mem_resp=1. A new request may start the cycle after resp.
- Registers: fetch_pc; squash_pc; queue of 2 entries {pc, inst}; count 0..2. Address equals fetch_pc in REQ and the old fetch_pc in SQUASH.
- pop = advance && if_valid && !redirect.
- push = (state==REQ) && inst_mem_resp && !redirect.
- cnt_next = count + push - pop. Push and pop in the same cycle are both honoured (FIFO order preserved).
- REQ state:
  - resp without redirect: push {fetch_pc, rdata}; fetch_pc += 4 (mod 2^32). Next state is REQ if cnt_next<2, else IDLE.
  - redirect (with or without resp): clear queue. fetch_pc = redirect_pc.
    - With resp in the same cycle: data dropped, next state REQ.
    - Without resp: latch squash_pc = redirect_pc, next state SQUASH.
- IDLE state: go to REQ when cnt_next<2. On redirect: clear queue, fetch_pc = redirect_pc, go to REQ.
- SQUASH state:
  - Read held at the old address.
  - On resp: data dropped, fetch_pc = squash_pc, go to REQ.
  - Redirect while in SQUASH: overwrite squash_pc (and on a same-cycle resp, use the new redirect_pc); clear queue.
- Redirect has priority over advance and over push. Queue outputs are forced empty in the cycle after a redirect.
- Outputs: if_valid = (count!=0); if_pc/if_inst = head entry, or fetch_pc/NOP_INST when empty.
- Latency: the first read is asserted in the cycle after rst deasserts. A resp in cycle N makes the instruction visible (if_valid=1) in cycle N+1. Back-to-back throughput is one instruction per resp.
- Reset (rst=0, any state, including mid-request), in the following cycle:
  - state=IDLE, inst_mem_read=0, count=0;
  - fetch_pc = squash_pc = RESET_PC, inst_mem_address = RESET_PC;
  - if_valid=0, if_pc=RESET_PC, if_inst=NOP_INST.
  - An abandoned I-cache request is tolerated by the cache (its reset clears it).
- Full condition: count=2 without pop means no new request (IDLE). Empty condition: advance is ignored (no pop, no underflow).

Test Plan:
- Reset then fetch: hold rst=0 for 2 cycles, release; cache responds 1 cycle after each read with rdata=PC+0x1000; advance=1 always -> read asserted the cycle after release at 0x60; if_pc sequence 0x60, 0x64, 0x68 with if_inst 0x1060, 0x1064, 0x1068.
- Backpressure: advance=0, responses continuous -> exactly 2 pushes (0x60, 0x64), then read drops to 0 and IDLE is held. Raise advance for 1 cycle -> if_pc becomes 0x64 and a new read at 0x68 starts next cycle.
- Redirect mid-request: cache delays resp 3 cycles; pulse redirect (redirect_pc=0x200) while the read at 0x68 is outstanding -> address stays 0x68 until resp; data is dropped and never appears; next read is at 0x200; queue empty from the cycle after the redirect.
- Redirect coincident with resp: redirect (redirect_pc=0x303) in the same cycle as resp for 0x64 -> no push; next address 0x300 (low bits cleared); no SQUASH entered.
- Double redirect in SQUASH: redirect to 0x400, then to 0x500 before resp -> after resp, the read goes to 0x500 only.
- Reset mid-request: assert rst=0 while read is outstanding with count=1 -> the next cycle has read=0, if_valid=0, if_inst=0x00000013, address=0x60.

Source files
------------

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: RV32I fetch stage owning the PC, driving the I-cache read port
// and buffering fetched words in a 2-entry queue; redirects squash in-flight reads.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000060,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_mem_read,
    output logic [31:0] inst_mem_address,
    input  logic [31:0] inst_mem_rdata,
    input  logic        inst_mem_resp,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);
    typedef enum logic [1:0] {IDLE, REQ, SQUASH} state_t;
    state_t state, state_next;
    logic [31:0] fetch_pc, squash_pc, hold_pc, target;
    logic [31:0] q_pc [2];
    logic [31:0] q_inst [2];
    logic head;
    logic [1:0] count, cnt_next;
    logic pop, push;

    assign target = redirect_pc & ~32'd3;
    assign if_valid = count != 2'd0;
    assign pop = advance && if_valid && !redirect;
    assign push = state == REQ && inst_mem_resp && !redirect;
    assign cnt_next = count + {1'b0, push} - {1'b0, pop};
    assign inst_mem_read = state != IDLE;
    // hold_pc keeps the wrong-path address stable until the squashed read completes
    assign inst_mem_address = state == SQUASH ? hold_pc : fetch_pc;
    assign if_pc = if_valid ? q_pc[head] : fetch_pc;
    assign if_inst = if_valid ? q_inst[head] : NOP_INST;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = (redirect || cnt_next < 2'd2) ? REQ : IDLE;
            REQ:     state_next = redirect ? (inst_mem_resp ? REQ : SQUASH)
                                           : (push && cnt_next == 2'd2) ? IDLE : REQ;
            default: state_next = inst_mem_resp ? REQ : SQUASH;
        endcase
    end

    always_ff @(posedge clk)
        state <= !rst ? IDLE : state_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            squash_pc <= RESET_PC;
            hold_pc <= RESET_PC;
            count <= 2'd0;
            head <= 1'b0;
        end else begin
            if (redirect)
                fetch_pc <= target;
            else if (push)
                fetch_pc <= fetch_pc + 32'd4;
            else if (state == SQUASH && inst_mem_resp)
                fetch_pc <= squash_pc;
            if (redirect)
                squash_pc <= target;
            if (state != SQUASH)
                hold_pc <= fetch_pc;
            count <= redirect ? 2'd0 : cnt_next;
            head <= redirect ? 1'b0 : head ^ pop;
            // REQ never holds two entries, so the tail slot is free even on a same-cycle pop
            if (push) begin
                q_pc[head ^ count[0]] <= fetch_pc;
                q_inst[head ^ count[0]] <= inst_mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed plan plus random phase, checked cycle by cycle against
// a transaction-level model (pending request record + instruction queue).
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        advance = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        inst_mem_read;
    logic [31:0] inst_mem_address;
    logic [31:0] inst_mem_rdata = 32'd0;
    logic        inst_mem_resp = 1'b0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    localparam logic [31:0] RST_PC = 32'h00000060;
    localparam logic [31:0] NOP = 32'h00000013;

    if_fetch_unit dut (
        .clk(clk),
        .rst(rst),
        .advance(advance),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .inst_mem_read(inst_mem_read),
        .inst_mem_address(inst_mem_address),
        .inst_mem_rdata(inst_mem_rdata),
        .inst_mem_resp(inst_mem_resp),
        .if_valid(if_valid),
        .if_pc(if_pc),
        .if_inst(if_inst)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // reference model: one outstanding request record and a FIFO of fetched words
    logic [31:0] mq_pc [$];
    logic [31:0] mq_inst [$];
    bit          m_pending;
    bit          m_wrong;
    logic [31:0] m_addr;
    logic [31:0] m_pc;

    // cache behaviour
    int  lat = 1;
    int  busy = 0;
    bit  rand_mode = 0;

    function automatic void chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endfunction

    function automatic void model_edge(bit r, bit adv, bit rd, logic [31:0] rpc, bit rsp, logic [31:0] rdat);
        bit done;
        if (!r) begin
            mq_pc.delete();
            mq_inst.delete();
            m_pending = 0;
            m_wrong = 0;
            m_pc = RST_PC;
            m_addr = RST_PC;
            return;
        end
        done = m_pending && rsp;
        if (rd) begin
            mq_pc.delete();
            mq_inst.delete();
            m_pc = {rpc[31:2], 2'b00};
            if (m_pending && !done) m_wrong = 1;
            else begin
                m_pending = 1;
                m_wrong = 0;
                m_addr = m_pc;
            end
            return;
        end
        if (adv && mq_pc.size() > 0) begin
            void'(mq_pc.pop_front());
            void'(mq_inst.pop_front());
        end
        if (done) begin
            if (!m_wrong) begin
                mq_pc.push_back(m_addr);
                mq_inst.push_back(rdat);
                m_pc = m_addr + 32'd4;
            end
            m_pending = 0;
            m_wrong = 0;
        end
        if (!m_pending && mq_pc.size() < 2) begin
            m_pending = 1;
            m_addr = m_pc;
        end
    endfunction

    function automatic void check_model();
        bit v;
        v = mq_pc.size() > 0;
        chk("read", {31'd0, inst_mem_read}, {31'd0, m_pending});
        chk("valid", {31'd0, if_valid}, {31'd0, v});
        chk("if_pc", if_pc, v ? mq_pc[0] : m_pc);
        chk("if_inst", if_inst, v ? mq_inst[0] : NOP);
        if (m_pending) chk("addr", inst_mem_address, m_addr);
    endfunction

    task automatic step(input bit r, input bit adv, input bit rd, input logic [31:0] rpc);
        bit rd_now;
        rst = r;
        advance = adv;
        redirect = rd;
        redirect_pc = rpc;
        rd_now = inst_mem_read;
        inst_mem_resp = rd_now ? (busy >= lat) : (rand_mode ? 1'($urandom_range(0, 1)) : 1'b0);
        inst_mem_rdata = rd_now ? inst_mem_address + 32'h1000 : $urandom;
        @(posedge clk);
        model_edge(r, adv, rd, rpc, inst_mem_resp, inst_mem_rdata);
        if (!r) busy = 0;
        else if (rd_now && inst_mem_resp) begin
            busy = 0;
            if (rand_mode) lat = $urandom_range(0, 3);
        end else if (rd_now) busy++;
        #1;
        check_model();
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("rst_read", {31'd0, inst_mem_read}, 32'd0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_pc", if_pc, RST_PC);
        chk("rst_inst", if_inst, NOP);
        chk("rst_addr", inst_mem_address, RST_PC);
    endtask

    initial begin
        logic [31:0] seen [$];
        // reset then fetch with advance always high
        lat = 1;
        do_reset();
        step(1, 1, 0, 0);
        chk("first_read", {31'd0, inst_mem_read}, 32'd1);
        chk("first_addr", inst_mem_address, 32'h60);
        for (int i = 0; i < 12; i++) begin
            if (if_valid && (seen.size() == 0 || seen[$] != if_pc)) seen.push_back(if_pc);
            if (if_valid && if_pc == 32'h60) chk("inst_60", if_inst, 32'h1060);
            if (if_valid && if_pc == 32'h68) chk("inst_68", if_inst, 32'h1068);
            step(1, 1, 0, 0);
        end
        chk("seq_len_ok", {31'd0, seen.size() >= 3}, 32'd1);
        if (seen.size() >= 3) begin
            chk("seq0", seen[0], 32'h60);
            chk("seq1", seen[1], 32'h64);
            chk("seq2", seen[2], 32'h68);
        end

        // backpressure with back-to-back responses
        lat = 0;
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
        chk("full_read", {31'd0, inst_mem_read}, 32'd0);
        chk("full_pc", if_pc, 32'h60);
        step(1, 1, 0, 0);
        chk("pop_pc", if_pc, 32'h64);
        chk("refill_read", {31'd0, inst_mem_read}, 32'd1);
        chk("refill_addr", inst_mem_address, 32'h68);

        // redirect while read at 0x68 is outstanding
        lat = 3;
        step(1, 0, 1, 32'h200);
        chk("sq_addr", inst_mem_address, 32'h68);
        chk("sq_valid", {31'd0, if_valid}, 32'd0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        chk("sq_new_addr", inst_mem_address, 32'h200);
        chk("sq_empty", {31'd0, if_valid}, 32'd0);

        // redirect coincident with resp for 0x64
        lat = 1;
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        step(1, 0, 1, 32'h303);
        chk("co_addr", inst_mem_address, 32'h300);
        chk("co_valid", {31'd0, if_valid}, 32'd0);
        step(1, 0, 0, 0);
        chk("co_no_squash", inst_mem_address, 32'h300);

        // double redirect while squashing
        lat = 3;
        step(1, 0, 1, 32'h400);
        chk("dbl_hold", inst_mem_address, 32'h300);
        step(1, 0, 1, 32'h500);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("dbl_addr", inst_mem_address, 32'h500);

        // reset mid-request with one entry queued
        lat = 1;
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        chk("mid_count1", {31'd0, if_valid}, 32'd1);
        step(0, 0, 0, 0);
        chk("mid_read", {31'd0, inst_mem_read}, 32'd0);
        chk("mid_valid", {31'd0, if_valid}, 32'd0);
        chk("mid_inst", if_inst, NOP);
        chk("mid_addr", inst_mem_address, RST_PC);

        // random phase
        rand_mode = 1;
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 63) != 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 15) == 0, $urandom & 32'h0000fffe);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
